// File: rtl/pcpu_pkg.sv
// Shared definitions for the pipelined MIPS CPU.
// Holds the ALU op codes, the conditional-branch type codes, the widths of
// those fields, and the execute-stage multiplier state type.
package pcpu_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned BR_W = 3;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND   = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR    = 4'h3;
  localparam logic [OP_W-1:0] ALU_SLL   = 4'h4;
  localparam logic [OP_W-1:0] ALU_SRL   = 4'h5;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'h6;
  localparam logic [OP_W-1:0] ALU_NOR   = 4'h7;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'h8;
  localparam logic [OP_W-1:0] ALU_SLTU  = 4'h9;
  localparam logic [OP_W-1:0] ALU_SRA   = 4'hA;
  localparam logic [OP_W-1:0] ALU_LUI   = 4'hB;
  localparam logic [OP_W-1:0] ALU_MULT  = 4'hC;
  localparam logic [OP_W-1:0] ALU_MULTU = 4'hD;
  localparam logic [OP_W-1:0] ALU_MFHI  = 4'hE;
  localparam logic [OP_W-1:0] ALU_MFLO  = 4'hF;

  localparam logic [BR_W-1:0] BR_NONE = 3'b000;
  localparam logic [BR_W-1:0] BR_EQ   = 3'b001;
  localparam logic [BR_W-1:0] BR_NE   = 3'b010;
  localparam logic [BR_W-1:0] BR_LEZ  = 3'b011;
  localparam logic [BR_W-1:0] BR_GTZ  = 3'b100;
  localparam logic [BR_W-1:0] BR_LTZ  = 3'b101;
  localparam logic [BR_W-1:0] BR_GEZ  = 3'b110;
  localparam logic [BR_W-1:0] BR_J    = 3'b111;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } mul_state_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Serial shift-add multiplier, one multiplier bit per step.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       load operands (magnitudes when signed_sel) and arm the counter
//   abort       drop the operation in progress
//   step        advance one shift-add iteration
//   signed_sel  treat a/b as two's-complement (sampled with start)
//   a, b        operands
//   done        high on the step that completes the product
//   prod        sign-corrected 2*XLEN product, valid while done is high
module mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              step,
  input  logic              signed_sel,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] prod
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              neg;

  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_nx;

  always_comb begin
    a_mag  = (signed_sel && a[XLEN-1]) ? (~a + 1'b1) : a;
    b_mag  = (signed_sel && b[XLEN-1]) ? (~b + 1'b1) : b;
    addend = acc[0] ? mcand : '0;
    // acc holds {partial product, remaining multiplier bits}; add into the
    // upper half and shift right so the next multiplier bit lands in acc[0].
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    acc_nx = {sum, acc[XLEN-1:1]};
    prod   = neg ? (~acc_nx + 1'b1) : acc_nx;
    done   = step && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      mcand <= a_mag;
      acc   <= {{XLEN{1'b0}}, b_mag};
      cnt   <= CW'(XLEN - 1);
      neg   <= signed_sel && (a[XLEN-1] ^ b[XLEN-1]);
    end else if (step) begin
      acc <= acc_nx;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage of the pipelined MIPS CPU.
// Registers the decoded instruction, computes the ALU result, resolves
// conditional branches, and runs an optional iterative multiplier with HI/LO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_*              decoded instruction fields from the decode stage
//   flush             kill the instruction held in EX (overrides everything)
//   mem_stall         memory stage cannot accept; EX holds
//   ex_ready          EX accepts id_* this cycle
//   ex_valid          EX output is a real instruction
//   ex_pc, ex_br_dst  registered PC and branch target
//   ex_result         ALU / multiplier result
//   ex_mem_*, ex_rf_* registered pass-throughs (write enables gated by valid)
//   ex_br_taken       branch resolved taken
//   ex_busy           multiplier running
module exec_stage
  import pcpu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [OP_W-1:0] id_op,
  input  logic [XLEN-1:0] id_opa,
  input  logic [XLEN-1:0] id_opb,
  input  logic            id_mem_we,
  input  logic [XLEN-1:0] id_mem_data,
  input  logic            id_rf_we,
  input  logic [4:0]      id_rf_dst,
  input  logic [1:0]      id_rf_src,
  input  logic [BR_W-1:0] id_br_type,
  input  logic [XLEN-1:0] id_br_dst,
  input  logic            flush,
  input  logic            mem_stall,
  output logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_result,
  output logic            ex_mem_we,
  output logic [XLEN-1:0] ex_mem_data,
  output logic            ex_rf_we,
  output logic [4:0]      ex_rf_dst,
  output logic [1:0]      ex_rf_src,
  output logic            ex_br_taken,
  output logic [XLEN-1:0] ex_br_dst,
  output logic            ex_busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  mul_state_t      state, state_nx;
  logic            valid_r;
  logic [XLEN-1:0] pc_r, opa_r, result_r, mem_data_r, br_dst_r;
  logic            mem_we_r, rf_we_r;
  logic [4:0]      rf_dst_r;
  logic [1:0]      rf_src_r;
  logic [BR_W-1:0] br_type_r;
  logic [XLEN-1:0] hi, lo;

  logic              capture;
  logic              mul_start, mul_step, mul_done;
  logic [2*XLEN-1:0] mul_prod;
  logic              zero, br_cond;

  function automatic logic [XLEN-1:0] alu(
    input logic [OP_W-1:0] op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [XLEN-1:0] hi_v,
    input logic [XLEN-1:0] lo_v
  );
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] r;
    sh = a[SHW-1:0];
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
      ALU_SRA:  r = $signed(b) >>> sh;
      ALU_LUI:  r = b << 16;
      ALU_MFHI: r = MUL_EN ? hi_v : '0;
      ALU_MFLO: r = MUL_EN ? lo_v : '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign ex_busy   = (state != MS_IDLE);
  assign ex_ready  = !ex_busy && !mem_stall;
  assign capture   = ex_ready && !flush;
  assign mul_start = MUL_EN && capture && id_valid && is_mul_op(id_op);
  assign mul_step  = (state == MS_RUN) && !mem_stall && !flush;

  always_comb begin
    state_nx = state;
    case (state)
      MS_IDLE: if (mul_start)  state_nx = MS_RUN;
      MS_RUN:  if (mul_done)   state_nx = MS_DONE;
      MS_DONE: if (!mem_stall) state_nx = MS_IDLE;
      default: state_nx = MS_IDLE;
    endcase
    if (flush) state_nx = MS_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MS_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mul_done) begin
      {hi, lo} <= mul_prod;
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      mul_iter #(.XLEN(XLEN)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .abort      (flush),
        .step       (mul_step),
        .signed_sel (id_op == ALU_MULT),
        .a          (id_opa),
        .b          (id_opb),
        .done       (mul_done),
        .prod       (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      pc_r       <= '0;
      opa_r      <= '0;
      result_r   <= '0;
      mem_we_r   <= 1'b0;
      mem_data_r <= '0;
      rf_we_r    <= 1'b0;
      rf_dst_r   <= '0;
      rf_src_r   <= '0;
      br_type_r  <= '0;
      br_dst_r   <= '0;
    end else begin
      // A finished multiply leaves EX when DONE exits; clearing valid there
      // keeps it from being presented downstream a second time.
      if (flush)                                valid_r <= 1'b0;
      else if (capture)                         valid_r <= id_valid;
      else if (state == MS_DONE && !mem_stall)  valid_r <= 1'b0;

      if (capture) begin
        pc_r       <= id_pc;
        opa_r      <= id_opa;
        result_r   <= alu(id_op, id_opa, id_opb, hi, lo);
        mem_we_r   <= id_mem_we;
        mem_data_r <= id_mem_data;
        rf_we_r    <= id_rf_we;
        rf_dst_r   <= id_rf_dst;
        rf_src_r   <= id_rf_src;
        br_type_r  <= id_br_type;
        br_dst_r   <= id_br_dst;
      end
    end
  end

  always_comb begin
    zero = (ex_result == '0);
    case (br_type_r)
      BR_EQ:   br_cond = zero;
      BR_NE:   br_cond = !zero;
      BR_LEZ:  br_cond = opa_r[XLEN-1] || (opa_r == '0);
      BR_GTZ:  br_cond = !opa_r[XLEN-1] && (opa_r != '0);
      BR_LTZ:  br_cond = opa_r[XLEN-1];
      BR_GEZ:  br_cond = !opa_r[XLEN-1];
      BR_J:    br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign ex_valid    = valid_r && (state != MS_RUN);
  assign ex_result   = (state == MS_DONE) ? lo : result_r;
  assign ex_pc       = pc_r;
  assign ex_mem_we   = mem_we_r && ex_valid;
  assign ex_mem_data = mem_data_r;
  assign ex_rf_we    = rf_we_r && ex_valid;
  assign ex_rf_dst   = rf_dst_r;
  assign ex_rf_src   = rf_src_r;
  assign ex_br_taken = br_cond && ex_valid;
  assign ex_br_dst   = br_dst_r;

endmodule
